// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the round-robin search used by the packet arbiter.
package axis_packet_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_IN = 16;
    localparam int PTR_W  = 4;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set request strictly after ptr, wrapping; ptr itself is checked last.
    function automatic rr_pick_t find_next(input logic [MAX_IN-1:0] req,
                                           input logic [PTR_W-1:0]  ptr,
                                           input int                n);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int off = MAX_IN; off >= 1; off--) begin
            cand = (int'(ptr) + off) % n;
            if (off <= n && req[cand[PTR_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[PTR_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle between NUM_IN sources, the arbiter and one downstream sink.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never
// waits on ready, and data/keep/last hold stable while valid && !ready.
interface axis_packet_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_IN          = 4
);
    logic [NUM_IN-1:0]                 s_valid;
    logic [NUM_IN*DATA_WIDTH-1:0]      s_data;
    logic [NUM_IN*DATA_BYTE_WIDTH-1:0] s_keep;
    logic [NUM_IN-1:0]                 s_last;
    logic [NUM_IN-1:0]                 s_ready;
    logic                              m_valid;
    logic [DATA_WIDTH-1:0]             m_data;
    logic [DATA_BYTE_WIDTH-1:0]        m_keep;
    logic                              m_last;
    logic                              m_ready;

    // master is the arbiter; slave is the surrounding sources and sink.
    modport master (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );

    modport slave (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );
endinterface

// File: rtl/axis_packet_arbiter_skid_buffer.sv
// Two-entry registered skid buffer: all outputs, including in_ready, come from flops.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             out_free;
    logic             in_fire;
    logic             skid_next;

    assign out_free  = out_ready || !out_valid;
    assign in_fire   = in_valid && in_ready;
    assign skid_next = out_free ? 1'b0 : (skid_valid || in_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            in_ready   <= !skid_next;
            skid_valid <= skid_next;
            if (out_free) begin
                // in_ready is low whenever the skid slot is occupied, so no new beat competes here.
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else if (in_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_fire && !skid_valid) begin
                skid_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the output from first beat to last.
module axis_packet_arbiter
    import axis_packet_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_IN          = 4,
    parameter int ID_WIDTH        = $clog2(NUM_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_packet_arbiter_if.master bus,
    output logic [ID_WIDTH-1:0]   grant_id,
    output logic                  busy
);
    localparam int BEAT_W = DATA_WIDTH + DATA_BYTE_WIDTH + 1;

    arb_state_t          state;
    logic [ID_WIDTH-1:0] last_grant;
    rr_pick_t            pick;
    logic                granted_valid;
    logic                granted_last;
    logic                buf_in_valid;
    logic                buf_in_ready;
    logic                buf_out_valid;
    logic                accept;
    logic [BEAT_W-1:0]   buf_in_beat;
    logic [BEAT_W-1:0]   buf_out_beat;

    assign pick = find_next(MAX_IN'(bus.s_valid), PTR_W'(last_grant), NUM_IN);

    assign granted_valid = bus.s_valid[grant_id];
    assign granted_last  = bus.s_last[grant_id];
    assign buf_in_valid  = (state == LOCKED) && granted_valid;
    assign accept        = buf_in_valid && buf_in_ready;
    assign buf_in_beat   = {granted_last,
                            bus.s_keep[grant_id*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH],
                            bus.s_data[grant_id*DATA_WIDTH +: DATA_WIDTH]};

    // Only the locked source ever sees ready, and only when the buffer can take a beat.
    assign bus.s_ready = (state == LOCKED && buf_in_ready) ? (NUM_IN'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_WIDTH'(NUM_IN - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        grant_id <= ID_WIDTH'(pick.idx);
                        busy     <= 1'b1;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && granted_last) begin
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skid_buffer #(.WIDTH(BEAT_W)) u_skid (
        .clk       (clk),
        .rst       (!rst_n),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in_beat),
        .out_valid (buf_out_valid),
        .out_ready (bus.m_ready),
        .out_data  (buf_out_beat)
    );

    assign bus.m_valid = buf_out_valid;
    assign {bus.m_last, bus.m_keep, bus.m_data} = buf_out_beat;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter with a beat scoreboard on the output.
module tb_axis_packet_arbiter;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int BW = DW + KW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_packet_arbiter_if #(.DATA_WIDTH(DW), .DATA_BYTE_WIDTH(KW), .NUM_IN(N)) bus ();

    logic [IW-1:0]   grant_id;
    logic            busy;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_last;
    logic [N-1:0]    hold;
    logic [N*DW-1:0] s_data;
    logic [N*KW-1:0] s_keep;
    logic            m_ready;

    assign bus.s_valid = s_valid;
    assign bus.s_data  = s_data;
    assign bus.s_keep  = s_keep;
    assign bus.s_last  = s_last;
    assign bus.m_ready = m_ready;

    axis_packet_arbiter #(.DATA_WIDTH(DW), .DATA_BYTE_WIDTH(KW), .NUM_IN(N), .ID_WIDTH(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] src_q[N][$];
    int total = 0;
    int bad = 0;
    int mr_mode = 0;
    int mr_idx = 0;
    int stall_acc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int data, input logic [KW-1:0] keep, input logic last);
        return {last, keep, DW'(data)};
    endfunction

    task automatic push_pkt(input int src, input int tagv, input int len, input logic [KW-1:0] last_keep);
        logic [BW-1:0] bt;
        for (int b = 0; b < len; b++) begin
            bt = mk(tagv + b, (b == len - 1) ? last_keep : 4'hF, b == len - 1);
            src_q[src].push_back(bt);
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                s_valid[i] = 1'b1;
                {s_last[i], s_keep[i*KW +: KW], s_data[i*DW +: DW]} = src_q[i][0];
            end else begin
                s_valid[i] = 1'b0;
                {s_last[i], s_keep[i*KW +: KW], s_data[i*DW +: DW]} = '0;
            end
        end
    endtask

    // Entered at a falling edge with inputs settled; returns at the next falling edge.
    task automatic tick();
        logic [N-1:0]  s_fire;
        logic          m_fire;
        logic          stall_now;
        logic [BW-1:0] out_now;
        logic [BW-1:0] e;
        s_fire  = bus.s_valid & bus.s_ready;
        m_fire  = bus.m_valid && m_ready;
        out_now = {bus.m_last, bus.m_keep, bus.m_data};
        check("s_ready_onehot", 64'($onehot0(bus.s_ready)), 1);
        if (!busy) check("s_ready_idle", bus.s_ready, 0);
        if (m_fire) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_beat observed=%0h expected=none", out_now);
            end else begin
                e = exp_q.pop_front();
                check("beat", out_now, e);
            end
        end
        if (bus.m_valid && !m_ready) begin
            stall_acc += $countones(s_fire);
            check("stall_accept_le1", stall_acc <= 1, 1);
        end else begin
            stall_acc = 0;
        end
        for (int i = 0; i < N; i++) if (s_fire[i]) src_q[i].delete(0);
        stall_now = bus.m_valid && !m_ready;
        @(negedge clk);
        if (stall_now && rst_n) begin
            check("hold_valid", bus.m_valid, 1);
            check("hold_beat", {bus.m_last, bus.m_keep, bus.m_data}, out_now);
        end
        if (mr_mode == 1) begin
            m_ready = (mr_idx % 3 == 0);
            mr_idx++;
        end else begin
            m_ready = 1'b1;
        end
        drive_inputs();
    endtask

    task automatic wait_fire(input int src, input logic need_last, input int budget, input string tag);
        int n = 0;
        while (!(bus.s_valid[src] && bus.s_ready[src] && (!need_last || bus.s_last[src])) && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int n = 0;
        while (!busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || bus.m_valid) && n < budget) begin
            tick();
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        hold = '0;
        stall_acc = 0;
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold = '0;
        m_ready = 1'b1;
        drive_inputs();
        repeat (2) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_keep", bus.m_keep, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single source, three beats
        push_pkt(2, 'hA0, 3, 4'hF);
        drive_inputs();
        wait_busy(10, "t1_busy_wait");
        check("t1_grant_id", grant_id, 2);
        wait_fire(2, 1'b0, 10, "t1_first_fire");
        tick();
        check("t1_latency_valid", bus.m_valid, 1);
        check("t1_first_data", bus.m_data, 'hA0);
        check("t1_first_last", bus.m_last, 0);
        wait_fire(2, 1'b1, 10, "t1_last_fire");
        tick();
        check("t1_busy_fall", busy, 0);
        check("t1_last_beat", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, 1'b1, 32'hA2});
        drain(20, "t1_drain");

        // All four sources request after reset; source 0 has two packets
        do_reset();
        push_pkt(0, 'h100, 2, 4'hF);
        push_pkt(1, 'h200, 2, 4'hF);
        push_pkt(2, 'h300, 2, 4'hF);
        push_pkt(3, 'h400, 2, 4'hF);
        push_pkt(0, 'h110, 2, 4'hF);
        drive_inputs();
        wait_busy(10, "t2_busy_wait");
        check("t2_first_grant", grant_id, 0);
        drain(80, "t2_drain");

        // Backpressure on an eight-beat packet
        mr_mode = 1;
        mr_idx = 0;
        push_pkt(0, 'h500, 8, 4'hF);
        drive_inputs();
        drain(120, "t3_drain");
        mr_mode = 0;
        m_ready = 1'b1;

        // Granted source 1 pauses while source 3 waits
        push_pkt(1, 'h600, 4, 4'hF);
        push_pkt(3, 'h700, 2, 4'hF);
        drive_inputs();
        wait_busy(10, "t4_busy_wait");
        check("t4_grant", grant_id, 1);
        wait_fire(1, 1'b0, 10, "t4_fire_b1");
        tick();
        wait_fire(1, 1'b0, 10, "t4_fire_b2");
        tick();
        hold[1] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_s_ready3", bus.s_ready[3], 0);
            check("t4_grant_held", {busy, grant_id}, {1'b1, 2'd1});
        end
        hold[1] = 1'b0;
        drive_inputs();
        drain(40, "t4_drain");

        // Reset after beat 2 of a four-beat packet
        push_pkt(0, 'h800, 4, 4'hF);
        drive_inputs();
        wait_fire(0, 1'b0, 10, "t5_fire_b1");
        tick();
        wait_fire(0, 1'b0, 10, "t5_fire_b2");
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_m_valid", bus.m_valid, 0);
        check("t5_s_ready", bus.s_ready, 0);
        check("t5_busy", busy, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        rst_n = 1'b1;
        push_pkt(1, 'hA00, 2, 4'hF);
        push_pkt(3, 'h900, 2, 4'hF);
        drive_inputs();
        wait_busy(10, "t5_busy_wait");
        check("t5_grant_after_rst", grant_id, 1);
        drain(40, "t5_drain");

        // Partial keep on the last beat
        push_pkt(2, 'hB00, 2, 4'h7);
        drive_inputs();
        begin
            int n = 0;
            while (!(bus.m_valid && bus.m_last) && n < 20) begin
                tick();
                n++;
            end
            check("t6_last_seen", n < 20, 1);
        end
        check("t6_keep", bus.m_keep, 4'h7);
        check("t6_data", bus.m_data, 'hB01);
        drain(20, "t6_drain");
        check("final_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
